// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-read-port register file.
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  function automatic int unsigned rf_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between control logic (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD     = 2
);
  logic                           clr;
  logic                           busy;
  logic                           w_en;
  logic [ADDR_WIDTH-1:0]          w_addr;
  logic [DATA_WIDTH-1:0]          w_data;
  logic [NUM_RD-1:0]              r_en;
  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr;
  logic [NUM_RD*DATA_WIDTH-1:0]   r_data;

  modport master (output clr, w_en, w_addr, w_data, r_en, r_addr,
                  input  busy, r_data);
  modport slave  (input  clr, w_en, w_addr, w_data, r_en, r_addr,
                  output busy, r_data);
endinterface

// File: rtl/regfile_mp_rd_port.sv
// One read port: address mux, zero-register mask, write-first bypass and
// optional output register.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int          ADDR_WIDTH = 3,
  parameter int          DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int          REG_READ   = 1,
  parameter int          ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] mem [DEPTH],
  input  logic                  flush,
  input  logic                  r_en,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  input  logic                  wr_ok,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] rd_raw;

  // Zero-register mask wins over the bypass path.
  always_comb begin
    if ((ZERO_REG != 0) && (r_addr == '0))
      rd_raw = '0;
    else if ((REG_READ != 0) && wr_ok && (w_addr == r_addr))
      rd_raw = w_data;
    else
      rd_raw = mem[r_addr];
  end

  generate
    if (REG_READ != 0) begin : g_reg
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   q <= '0;
        else if (flush) q <= '0;
        else if (r_en)  q <= rd_raw;
      end
      assign r_data = q;
    end else begin : g_comb
      logic unused_comb;
      assign unused_comb = &{1'b0, clk, reset_n, r_en, wr_ok, w_addr, w_data};
      assign r_data = flush ? '0 : rd_raw;
    end
  endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with self-sequencing clear after reset
// or on request.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    NUM_RD     = 2,
  parameter int                    REG_READ   = 1,
  parameter int                    ZERO_REG   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic         clk,
  input logic         reset_n,
  regfile_mp_if.slave bus
);

  localparam int unsigned          DEPTH    = rf_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]  CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  rf_state_t                    state, state_nxt;
  logic [ADDR_WIDTH:0]          cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]        mem [DEPTH];
  logic                         busy, flush, wr_ok;
  logic [NUM_RD*DATA_WIDTH-1:0] r_data_all;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RF_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RF_CLEAR: begin
        if (bus.clr)               cnt_nxt = '0;
        else if (cnt == CNT_LAST) begin
          state_nxt = RF_READY;
          cnt_nxt   = '0;
        end else                   cnt_nxt = cnt + 1'b1;
      end
      RF_READY: begin
        if (bus.clr) begin
          state_nxt = RF_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = RF_CLEAR;
    endcase
  end

  assign busy  = (state == RF_CLEAR);
  // The clr cycle in READY also flushes registered outputs and drops writes.
  assign flush = (REG_READ != 0) ? (busy | bus.clr) : busy;
  assign wr_ok = !busy && !bus.clr && bus.w_en &&
                 !((ZERO_REG != 0) && (bus.w_addr == '0));

  always_ff @(posedge clk) begin
    if (busy)       mem[cnt[ADDR_WIDTH-1:0]] <= INIT_VAL;
    else if (wr_ok) mem[bus.w_addr]          <= bus.w_data;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .REG_READ   (REG_READ),
      .ZERO_REG   (ZERO_REG)
    ) u_port (
      .clk     (clk),
      .reset_n (reset_n),
      .mem     (mem),
      .flush   (flush),
      .r_en    (bus.r_en[i]),
      .r_addr  (bus.r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_ok   (wr_ok),
      .w_addr  (bus.w_addr),
      .w_data  (bus.w_data),
      .r_data  (r_data_all[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.busy   = busy;
  assign bus.r_data = r_data_all;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three variants (registered, registered+zero-reg,
// combinational) driven by one stimulus stream and checked against a model.
module tb_regfile_mp;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clr = 1'b0;
  logic       w_en = 1'b0;
  logic [2:0] w_addr = '0;
  logic [7:0] w_data = '0;
  logic [1:0] r_en = '0;
  logic [5:0] r_addr = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_RD(2)) ifa ();
  regfile_mp_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_RD(2)) ifb ();
  regfile_mp_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_RD(2)) ifc ();

  assign ifa.clr = clr;  assign ifa.w_en = w_en;  assign ifa.w_addr = w_addr;
  assign ifa.w_data = w_data;  assign ifa.r_en = r_en;  assign ifa.r_addr = r_addr;
  assign ifb.clr = clr;  assign ifb.w_en = w_en;  assign ifb.w_addr = w_addr;
  assign ifb.w_data = w_data;  assign ifb.r_en = r_en;  assign ifb.r_addr = r_addr;
  assign ifc.clr = clr;  assign ifc.w_en = w_en;  assign ifc.w_addr = w_addr;
  assign ifc.w_data = w_data;  assign ifc.r_en = r_en;  assign ifc.r_addr = r_addr;

  regfile_mp #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_RD(2), .REG_READ(1), .ZERO_REG(0))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  regfile_mp #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_RD(2), .REG_READ(1), .ZERO_REG(1))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));
  regfile_mp #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .NUM_RD(2), .REG_READ(0), .ZERO_REG(0))
    dut_c (.clk(clk), .reset_n(reset_n), .bus(ifc));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-variant memory image, registered read values, and remaining clear cycles.
  int         zero_p [3] = '{0, 1, 0};
  int         regr_p [3] = '{1, 1, 0};
  logic [7:0] m_mem  [3][8];
  logic [7:0] m_rd   [3][2];
  bit         m_busy = 1;
  int         m_left = 8;

  initial begin
    for (int d = 0; d < 3; d++) begin
      for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
      m_rd[d][0] = '0;
      m_rd[d][1] = '0;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1;
      m_left = 8;
      for (int d = 0; d < 3; d++) begin
        for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
        m_rd[d][0] = '0;
        m_rd[d][1] = '0;
      end
    end else if (m_busy || clr) begin
      for (int d = 0; d < 3; d++) begin
        m_rd[d][0] = '0;
        m_rd[d][1] = '0;
      end
      if (clr) begin
        m_busy = 1;
        m_left = 8;
        for (int d = 0; d < 3; d++)
          for (int a = 0; a < 8; a++) m_mem[d][a] = '0;
      end else begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        for (int p = 0; p < 2; p++) begin
          logic [2:0] a;
          a = r_addr[p*3 +: 3];
          if (r_en[p]) begin
            if (zero_p[d] != 0 && a == 0)  m_rd[d][p] = 8'h00;
            else if (w_en && w_addr == a)  m_rd[d][p] = w_data;
            else                           m_rd[d][p] = m_mem[d][a];
          end
        end
        if (w_en && !(zero_p[d] != 0 && w_addr == 0)) m_mem[d][w_addr] = w_data;
      end
    end
  end

  function automatic logic [7:0] model_out(input int d, input int p);
    logic [2:0] a;
    a = r_addr[p*3 +: 3];
    if (regr_p[d] != 0)               return m_rd[d][p];
    if (m_busy)                       return 8'h00;
    if (zero_p[d] != 0 && a == 0)     return 8'h00;
    return m_mem[d][a];
  endfunction

  always @(negedge clk) begin
    if (started) begin
      logic [15:0] act [3];
      act[0] = ifa.r_data;
      act[1] = ifb.r_data;
      act[2] = ifc.r_data;
      chk("cmp_busy_a", 32'(ifa.busy), 32'(m_busy));
      chk("cmp_busy_b", 32'(ifb.busy), 32'(m_busy));
      chk("cmp_busy_c", 32'(ifc.busy), 32'(m_busy));
      for (int d = 0; d < 3; d++)
        for (int p = 0; p < 2; p++)
          chk($sformatf("cmp_rdata_d%0d_p%0d", d, p),
              32'(act[d][p*8 +: 8]), 32'(model_out(d, p)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (ifa.busy && n < 40);
    chk(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step(); step();
    started = 1;
    chk("reset_busy", 32'(ifa.busy), 32'd1);
    chk("reset_rdata_a", 32'(ifa.r_data), 32'h0000);
    chk("reset_rdata_b", 32'(ifb.r_data), 32'h0000);
    reset_n = 1'b1;
    wait_ready("reset_clear_cycles", 8);
    chk("ready_busy_low", 32'(ifa.busy), 32'd0);

    r_en = 2'b11;
    for (int a = 0; a < 8; a++) begin
      r_addr = {3'(a), 3'(a)};
      step();
      chk($sformatf("post_reset_read_%0d", a), 32'(ifa.r_data), 32'h0000);
    end

    // Write 0xA5 to addr 3, read on both ports.
    r_en = 2'b00; w_en = 1; w_addr = 3; w_data = 8'hA5;
    step();
    w_en = 0; r_addr = {3'd3, 3'd3}; r_en = 2'b11;
    step();
    chk("read_a5_reg", 32'(ifa.r_data), 32'hA5A5);
    chk("read_a5_comb", 32'(ifc.r_data), 32'hA5A5);

    // Seed addr 6, then write-first bypass on port 0 with port 1 on addr 6.
    w_en = 1; w_addr = 6; w_data = 8'h66; r_en = 2'b00;
    step();
    w_en = 1; w_addr = 5; w_data = 8'h3C; r_addr = {3'd6, 3'd5}; r_en = 2'b11;
    #1;
    chk("comb_no_bypass", 32'(ifc.r_data), 32'h6600);
    step();
    chk("bypass_reg", 32'(ifa.r_data), 32'h663C);
    chk("after_write_comb", 32'(ifc.r_data), 32'h663C);

    // Port 1 disabled while addr 6 changes.
    w_en = 1; w_addr = 6; w_data = 8'h99; r_en = 2'b01;
    step();
    w_en = 0;
    step();
    chk("hold_port1", 32'(ifa.r_data), 32'h663C);
    r_en = 2'b11;
    step();
    chk("port1_updated", 32'(ifa.r_data), 32'h993C);

    // Zero register: write 0xFF to addr 0 with bypass read on port 0.
    w_en = 1; w_addr = 0; w_data = 8'hFF; r_addr = {3'd1, 3'd0}; r_en = 2'b11;
    step();
    chk("zero_bypass_b", 32'(ifb.r_data[7:0]), 32'h00);
    chk("nozero_bypass_a", 32'(ifa.r_data[7:0]), 32'hFF);
    w_en = 1; w_addr = 1; w_data = 8'h42;
    step();
    w_en = 0;
    step();
    chk("zero_read_b", 32'(ifb.r_data), 32'h4200);
    chk("nozero_read_a", 32'(ifa.r_data), 32'h42FF);

    // Fill 0x11..0x88, clear, with a write issued mid-clear.
    for (int a = 0; a < 8; a++) begin
      w_en = 1; w_addr = 3'(a); w_data = 8'((a + 1) * 17);
      step();
    end
    w_en = 0; r_addr = {3'd7, 3'd2};
    step();
    chk("fill_read", 32'(ifa.r_data), 32'h8833);
    clr = 1;
    step();
    clr = 0;
    chk("clr_busy", 32'(ifa.busy), 32'd1);
    chk("clr_rdata", 32'(ifa.r_data), 32'h0000);
    step(); step();
    w_en = 1; w_addr = 2; w_data = 8'h77;
    step();
    w_en = 0;
    wait_ready("clr_remaining_cycles", 5);
    for (int a = 0; a < 8; a++) begin
      r_addr = {3'(a), 3'(a)};
      step();
      chk($sformatf("post_clr_read_%0d", a), 32'(ifa.r_data), 32'h0000);
    end

    // clr during CLEAR restarts the count.
    clr = 1;
    step();
    clr = 0;
    step(); step(); step();
    clr = 1;
    step();
    clr = 0;
    wait_ready("clr_restart_cycles", 8);

    // Asynchronous reset mid-cycle.
    w_en = 1; w_addr = 4; w_data = 8'h5A;
    step();
    w_en = 0; r_addr = {3'd4, 3'd4};
    step();
    chk("pre_async_read", 32'(ifa.r_data), 32'h5A5A);
    #2;
    reset_n = 0;
    #1;
    chk("async_busy", 32'(ifa.busy), 32'd1);
    chk("async_rdata_a", 32'(ifa.r_data), 32'h0000);
    chk("async_rdata_b", 32'(ifb.r_data), 32'h0000);
    step();
    reset_n = 1;
    wait_ready("async_clear_cycles", 8);
    step();
    chk("post_async_read", 32'(ifa.r_data), 32'h0000);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the single-port 8x8 register file used in the datapath.
- Adds the following over the single-port version:
  - NUM_RD independent read ports.
  - Selectable combinational or registered read, with write-first bypass in registered mode.
  - Optional hard-wired zero register.
  - Self-sequencing memory clear after reset or on request.
- Sits between decode/control logic and the execution datapath as the general-purpose operand store.

Parameters:
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, bits per entry.
- NUM_RD, 2, number of read ports (1..4).
- REG_READ, 1, 0 = combinational read, 1 = registered read (1-cycle latency).
- ZERO_REG, 0, 1 = address 0 always reads 0 and writes to it are discarded.
- INIT_VAL, 0, DATA_WIDTH-wide value written to every entry during clear.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous request to re-run the memory clear.
- busy  out  1  high while the clear sequence runs.
- w_en  in  1  write enable.
- w_addr  in  ADDR_WIDTH  write address.
- w_data  in  DATA_WIDTH  write data.
- r_en  in  NUM_RD  per-port read enable (registered mode only; ignored when REG_READ=0).
- r_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- r_data  out  NUM_RD*DATA_WIDTH  packed read data; port i at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset:
  - reset_n low asynchronously forces state=CLEAR, clear counter=0, busy=1, all r_data registers=0.
  - Memory contents are not reset directly; they are rewritten by the CLEAR sequence.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes INIT_VAL to memory[cnt], then cnt++. When cnt = depth-1 is written, go to READY next cycle. busy=1 throughout, so CLEAR lasts exactly 2**ADDR_WIDTH cycles.
  - READY: busy=0. clr=1 sampled at a rising edge moves to CLEAR with cnt=0. In that same cycle any w_en is ignored and r_data registers load 0.
- clr asserted while already in CLEAR restarts cnt at 0.
- Writes:
  - Only in READY with w_en=1: memory[w_addr] <= w_data at the rising edge.
  - w_en during CLEAR is dropped silently; the write is not queued.
  - With ZERO_REG=1, a write to address 0 is discarded.
- Read, REG_READ=0:
  - r_data[i] = memory[r_addr[i]] combinationally.
  - No bypass: a same-cycle write is visible only after the edge.
  - Forced to 0 while busy=1.
- Read, REG_READ=1:
  - At an edge with r_en[i]=1, r_data[i] <= memory[r_addr[i]]. With r_en[i]=0, r_data[i] holds.
  - Write-first bypass: if w_en accepted and w_addr == r_addr[i] in the same cycle, r_data[i] <= w_data.
  - While busy=1, r_data[i] <= 0 regardless of r_en.
- ZERO_REG=1: any read of address 0 returns 0 in both modes, with no bypass.
- Multiple ports may read the same address simultaneously; all get identical data.
- No write conflicts are possible, since there is one write port.
- Clear counter is ADDR_WIDTH+1 bits wide so the terminal comparison does not wrap.

Decomposition:
- Shared package regfile_pkg:
  - state enum rf_state_t {RF_CLEAR, RF_READY}.
  - localparam function for depth.
  - no other typedefs needed.
- One sub-module is natural: regfile_rd_port, a single read port containing the mux, bypass compare, zero mask and optional output register. It is instantiated NUM_RD times in a generate loop.
- Memory array and FSM stay in the top level.

Test Plan:
- Reset release with default parameters → busy=1 for exactly 8 cycles, then 0. After that, every address reads 0x00 on both ports.
- READY, write 0xA5 to addr 3, then r_addr[0]=3 and r_addr[1]=3 with r_en=2'b11 → both r_data = 0xA5 one cycle later (REG_READ=1).
- Same cycle: w_en=1, w_addr=5, w_data=0x3C, r_addr[0]=5, r_en[0]=1 → r_data[0]=0x3C next cycle (bypass). r_addr[1]=6 returns its old value.
- Fill all 8 entries with 0x11..0x88, then pulse clr → busy=1 for 8 cycles. A w_en of 0x77 to addr 2 issued mid-clear is dropped, and all entries read 0x00 afterwards.
- ZERO_REG=1: write 0xFF to addr 0 → reads of addr 0 return 0x00, including in the bypass case. Addr 1 behaves normally.
- REG_READ=1: hold r_en[1]=0 while memory changes → r_data[1] unchanged. Assert reset_n low mid-operation → r_data=0 and busy=1 immediately, without waiting for a clock edge.
